// File: rtl/gate_lab_pkg.sv
// ---------------------------------------------------------------------------
// gate_lab_pkg
//   Shared constants for the gate lab. The truth tables hold the expected y
//   of a 2-input gate, with the bit index = {a,b}. The package also holds the
//   state encoding of the checker FSM.
// ---------------------------------------------------------------------------
package gate_lab_pkg;

   localparam logic [3:0] TT_AND  = 4'b1000;
   localparam logic [3:0] TT_OR   = 4'b1110;
   localparam logic [3:0] TT_NAND = 4'b0111;
   localparam logic [3:0] TT_NOR  = 4'b0001;
   localparam logic [3:0] TT_XOR  = 4'b0110;
   localparam logic [3:0] TT_XNOR = 4'b1001;

   typedef enum logic {
      IDLE   = 1'b0,
      SETTLE = 1'b1
   } state_e;

endpackage

// File: rtl/gate_tt_checker.sv
// ---------------------------------------------------------------------------
// gate_tt_checker
//   Drives the four input vectors {a,b}=00,01,10,11 into a 2-input gate under
//   test. After each vector it waits SETTLE_CYCLES idle cycles, then samples
//   y_in on the next edge and compares it with EXP_TT[{a,b}]. It reports
//   pass/fail, a mismatch count and a per-vector fail mask.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   begin a run (sampled only when idle)
//   y_in       in   output of the gate under test (no synchronizer)
//   a_out      out  stimulus a (MSB of the vector index)
//   b_out      out  stimulus b (LSB of the vector index)
//   busy       out  a run is in progress
//   done       out  one-cycle pulse at the end of a run
//   pass       out  last completed run had no mismatches
//   err_count  out  mismatch count of the current or last run (0..4)
//   fail_mask  out  bit i set = vector i mismatched
// ---------------------------------------------------------------------------
module gate_tt_checker
   import gate_lab_pkg::*;
#(
   parameter logic [3:0]  EXP_TT        = TT_NOR,
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       y_in,
   output logic       a_out,
   output logic       b_out,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_count,
   output logic [3:0] fail_mask
);

   // The counter is at least one bit wide, so SETTLE_CYCLES=0 still works.
   localparam int unsigned CW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_RELOAD = CW'(SETTLE_CYCLES);

   state_e        state_q, state_d;
   logic [1:0]    idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          pass_q, pass_d;
   logic [2:0]    err_q, err_d;
   logic [3:0]    mask_q, mask_d;
   logic          mism;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= 2'd0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= 3'd0;
         mask_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         mask_q  <= mask_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      pass_d  = pass_q;
      err_d   = err_q;
      mask_d  = mask_q;
      mism    = (y_in != EXP_TT[idx_q]);

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SETTLE;
               idx_d   = 2'd0;
               cnt_d   = CNT_RELOAD;
               busy_d  = 1'b1;
               pass_d  = 1'b0;
               err_d   = 3'd0;
               mask_d  = 4'd0;
            end
         end
         SETTLE: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
            end else begin
               // Sample edge: score the current vector, then advance or finish.
               if (mism) begin
                  mask_d[idx_q] = 1'b1;
                  err_d         = err_q + 3'd1;
               end
               if (idx_q == 2'd3) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  // err_q does not include this edge's mismatch yet.
                  pass_d  = (err_q == 3'd0) && !mism;
               end else begin
                  idx_d = idx_q + 2'd1;
                  cnt_d = CNT_RELOAD;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // The stimulus vector is the vector index itself. It holds 11 after a run.
   assign a_out     = idx_q[1];
   assign b_out     = idx_q[0];
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_count = err_q;
   assign fail_mask = mask_q;

endmodule
